// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit.
// Holds CSR addresses, the csr_op encoding, trap cause codes, the bit
// positions of the mstatus/mie/mip fields in use, and the mstatus reset
// constant.
package csr_pkg;

  // Implemented CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  // Read/modify/write operation requested by the decoder
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // mcause exception / interrupt codes
  localparam int CAUSE_ECALL_M = 11;
  localparam int CAUSE_MTI     = 7;

  // Field positions
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MTIP_BIT     = 7;

  // mstatus after reset: MIE=MPIE=0, MPP hard-wired to machine mode (2'b11)
  localparam logic [15:0] MSTATUS_RESET = 16'h1800;

endpackage

// File: rtl/csr_if.sv
// CSR access bus between the execute-stage decoder and csr_unit.
//   csr_op_i      operation (none/rw/rs/rc)
//   csr_rd_i      CSR instruction present, read requested
//   csr_idx_i     12-bit CSR address
//   csr_wdata_i   rs1 / zimm operand
//   csr_rdata_o   old CSR value (combinational)
//   csr_illegal_o read of an unimplemented address
// master: the decoder side; slave: csr_unit.
interface csr_if #(
  parameter int XLEN = 64
) ();

  logic [1:0]      csr_op_i;
  logic            csr_rd_i;
  logic [11:0]     csr_idx_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_illegal_o;

  modport master (
    output csr_op_i, csr_rd_i, csr_idx_i, csr_wdata_i,
    input  csr_rdata_o, csr_illegal_o
  );

  modport slave (
    input  csr_op_i, csr_rd_i, csr_idx_i, csr_wdata_i,
    output csr_rdata_o, csr_illegal_o
  );

endinterface

// File: rtl/csr_counter.sv
// Free-running wrap-around counter used for mcycle and minstret.
//   clk, rst_n  clock, async active-low reset (clears to 0)
//   inc         add one this cycle
//   wr_en       load wr_data this cycle (takes precedence over inc)
//   wr_data     load value
//   q           current count
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      cnt_d = wr_data;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1); // wraps from all-ones to zero
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer beside the execute stage.
//   clk, rst_n      clock, async active-low reset
//   bus             csr_if slave: CSR read/modify/write access
//   pc_i            pc of the instruction in the stage
//   valid_i         instruction is valid and retires this cycle
//   ecall_i/mret_i  decoded ecall / mret
//   timer_irq_i     level machine-timer interrupt
//   redirect_o      trap entry or mret this cycle (combinational)
//   redirect_pc_o   target pc (combinational, from pre-update mtvec/mepc)
//
// Qualification: valid_i is the single "this instruction takes effect"
// strobe. ecall/mret/interrupt and CSR writes only act when it is high;
// CSR reads (rdata/illegal) are purely combinational on csr_rd_i/csr_idx_i.
module csr_unit
  import csr_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1,
  parameter bit CNT_EN      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_if.slave            bus,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            timer_irq_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  // Architectural state. mstatus and mie keep only their writable bits.
  logic            mie_q,  mie_d;   // mstatus.MIE
  logic            mpie_q, mpie_d;  // mstatus.MPIE
  logic            mtie_q, mtie_d;  // mie.MTIE
  logic [XLEN-1:0] mtvec_q,    mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q,     mepc_d;
  logic [XLEN-1:0] mcause_q,   mcause_d;
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;

  logic            irq_take;
  logic            exc_take;
  logic            trap;
  logic            mret_take;
  logic            implemented;
  logic            csr_we;
  logic            cyc_we;
  logic            ret_we;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] wval;
  logic [XLEN-1:0] mtvec_base;

  localparam logic [XLEN-1:0] ALIGN4_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  // Trap priority: interrupt > ecall > mret > CSR write
  assign irq_take  = valid_i & mie_q & mtie_q & timer_irq_i;
  assign exc_take  = valid_i & ecall_i;
  assign trap      = irq_take | exc_take;
  assign mret_take = valid_i & mret_i & ~trap;

  // Read mux; unimplemented addresses return zero
  always_comb begin
    rdata       = '0;
    implemented = 1'b1;
    case (bus.csr_idx_i)
      CSR_MSTATUS: begin
        // reset constant is exactly the fixed MPP field; OR in live bits
        rdata                   = XLEN'(MSTATUS_RESET);
        rdata[MSTATUS_MIE_BIT]  = mie_q;
        rdata[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE:      rdata[MIE_MTIE_BIT] = mtie_q;
      CSR_MTVEC:    rdata = mtvec_q;
      CSR_MSCRATCH: rdata = mscratch_q;
      CSR_MEPC:     rdata = mepc_q;
      CSR_MCAUSE:   rdata = mcause_q;
      CSR_MIP:      rdata[MIP_MTIP_BIT] = timer_irq_i;
      CSR_MCYCLE:   rdata = mcycle;
      CSR_MINSTRET: rdata = minstret;
      default:      implemented = 1'b0;
    endcase
  end

  assign bus.csr_rdata_o   = rdata;
  assign bus.csr_illegal_o = bus.csr_rd_i & ~implemented;

  // Modify value from the old (already masked) read value
  always_comb begin
    case (csr_op_e'(bus.csr_op_i))
      CSR_OP_RS: wval = rdata | bus.csr_wdata_i;
      CSR_OP_RC: wval = rdata & ~bus.csr_wdata_i;
      CSR_OP_RW: wval = bus.csr_wdata_i;
      default:   wval = bus.csr_wdata_i;
    endcase
  end

  // A trapping or returning instruction never writes a CSR
  assign csr_we = valid_i & bus.csr_rd_i & implemented &
                  (csr_op_e'(bus.csr_op_i) != CSR_OP_NONE) &
                  ~trap & ~mret_take;
  assign cyc_we = csr_we & (bus.csr_idx_i == CSR_MCYCLE);
  assign ret_we = csr_we & (bus.csr_idx_i == CSR_MINSTRET);

  // Next-state for trap sequencing and CSR writes
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    if (trap) begin
      mepc_d   = pc_i & ALIGN4_MASK;
      mcause_d = irq_take ? {1'b1, (XLEN-1)'(CAUSE_MTI)} : XLEN'(CAUSE_ECALL_M);
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_take) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (bus.csr_idx_i)
        CSR_MSTATUS: begin
          mie_d  = wval[MSTATUS_MIE_BIT];
          mpie_d = wval[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mtie_d = wval[MIE_MTIE_BIT];
        // bit1 is reserved-zero; bit0 (vectored mode) only kept when enabled
        CSR_MTVEC:    mtvec_d = {wval[XLEN-1:2], 1'b0, wval[0] & VECTORED_EN};
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d = wval & ALIGN4_MASK;
        CSR_MCAUSE:   mcause_d = wval;
        default: ; // mip read-only; counters handled by csr_counter
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtie_q     <= mtie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  // Counters
  generate
    if (CNT_EN) begin : g_cnt
      csr_counter #(.WIDTH(XLEN)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (1'b1),
        .wr_en   (cyc_we),
        .wr_data (wval),
        .q       (mcycle)
      );
      csr_counter #(.WIDTH(XLEN)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (valid_i & ~trap),
        .wr_en   (ret_we),
        .wr_data (wval),
        .q       (minstret)
      );
    end else begin : g_no_cnt
      assign mcycle   = '0;
      assign minstret = '0;
    end
  endgenerate

  // Redirect: exceptions always go to base; only interrupts use the vector
  assign mtvec_base = mtvec_q & ALIGN4_MASK;

  always_comb begin
    redirect_o    = trap | mret_take;
    redirect_pc_o = '0;
    if (trap) begin
      if (irq_take && mtvec_q[0]) begin
        redirect_pc_o = mtvec_base + XLEN'(4 * CAUSE_MTI);
      end else begin
        redirect_pc_o = mtvec_base;
      end
    end else if (mret_take) begin
      redirect_pc_o = mepc_q;
    end
  end

endmodule
